dreidel_pot_ledger: RTL and testbench
=====================================

Name: dreidel_pot_ledger

Overview:
- Downstream consumer of the dreidel game-action FSM.
- On each completed spin (`done` high), reads the 4-bit game state, settles the coin transfer between the single player and the pot, and enforces an ante when the pot empties.
- Drives the coin counts shown by the display/HUD logic.
- Exactly one settlement per spin, however long `done` is held.

Parameters:
- COIN_W, 8: width of the coin counters.
- START_COINS, 10: player coins loaded at reset and on newGame.
- START_POT, 4: pot coins loaded at reset and on newGame.
- ANTE, 1: coins moved player→pot when the pot reaches 0.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- newGame  in  1  synchronous reload of starting values
- gameState  in  4  action code from the game FSM: 0 IDLE, 1 SPIN, 2 NUN, 3 GIMEL, 4 HAY, 5 SHIN, 6 DONE
- done  in  1  high while the game FSM is in DONE
- playerCoins  out  COIN_W  player balance
- potCoins  out  COIN_W  pot balance
- updated  out  1  one-cycle pulse when a settlement (incl. ante) is committed
- broke  out  1  high when playerCoins == 0

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on `resetn`.
- Reset values: playerCoins = START_COINS, potCoins = START_POT, updated = 0, state = IDLE. `broke` is combinational from playerCoins.
- States: IDLE, APPLY, ANTE, WAIT_CLR.
- IDLE: at edge k with done = 1, latch gameState into `code` and go to APPLY. Otherwise stay.
- APPLY (edge k+1): commit the outcome for `code`, then go to ANTE.
  - NUN: no change.
  - GIMEL: player += pot; pot = 0.
  - HAY: half = (pot + 1) >> 1 (round up); player += half; pot -= half. pot = 0 gives no change.
  - SHIN: if player > 0, player -= 1 and pot += 1. Otherwise no change.
  - Any other code (0, 1, 6–15): no change (treated as NUN).
- ANTE (edge k+2): if pot == 0 and player >= ANTE, move ANTE coins player→pot. Otherwise no change. Go to WAIT_CLR with updated = 1 for exactly one cycle (the cycle after edge k+2).
- WAIT_CLR: updated = 0. Return to IDLE when done = 0; stay while done = 1.
- Latency: done sampled at edge k → outcome visible after k+1 → final balances and updated pulse after k+2.
- Arithmetic:
  - All sums computed at COIN_W+1 bits.
  - Player addition saturates at 2^COIN_W − 1. Any coins that do not fit remain in the pot, so no coins are lost.
  - pot += 1 on SHIN at pot max: the transfer is suppressed and player is unchanged.
  - Total coins (player + pot) are conserved in every transition except reset and newGame.
- newGame:
  - Synchronous, priority over all FSM activity.
  - Loads START_COINS / START_POT and clears updated.
  - Goes to WAIT_CLR if done = 1, else IDLE, so a stale result is never applied.
- Simultaneous events:
  - newGame in APPLY or ANTE aborts the settlement; only the reload takes effect.
  - Reset mid-operation returns immediately to reset values.
- done held high for many cycles produces a single settlement. done pulsed high for one cycle in IDLE is sufficient.

Test Plan:
- Reset, then GIMEL (code 3, done high 5 cycles): after the pulse player = 13, pot = 1 (14/0, then ante). updated high exactly 1 cycle.
- From reset, HAY with pot 4 → player 12, pot 2. Then HAY with pot 5 (preset via prior SHIN) → half = 3, pot 2.
- From reset, SHIN → player 9, pot 5. Drive player to 0 via repeated SHIN, then SHIN again → no change, broke = 1, total conserved.
- GIMEL with player 0 and pot 4 → player 4, pot 0 after APPLY; ante → player 3, pot 1. GIMEL with player 0 and pot 0 → ante skipped, pot stays 0.
- done held high 20 cycles with NUN → exactly one updated pulse, balances unchanged. Second done after done low → a second pulse.
- newGame asserted the cycle APPLY commits a GIMEL → balances exactly 10/4, no updated pulse. resetn dropped asynchronously mid-ANTE → outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/dreidel_pot_ledger.sv
// Dreidel pot ledger: settles player/pot coin transfers once per completed spin.
// Applies the outcome, then an ante if the pot ran dry, then waits for done to drop.
module dreidel_pot_ledger #(
  parameter int COIN_W      = 8,
  parameter int START_COINS = 10,
  parameter int START_POT   = 4,
  parameter int ANTE        = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              newGame,
  input  logic [3:0]        gameState,
  input  logic              done,
  output logic [COIN_W-1:0] playerCoins,
  output logic [COIN_W-1:0] potCoins,
  output logic              updated,
  output logic              broke
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_ANTE,
    S_WAIT
  } state_e;

  localparam logic [COIN_W-1:0] MAX    = {COIN_W{1'b1}};
  localparam logic [COIN_W-1:0] P_INIT = COIN_W'(START_COINS);
  localparam logic [COIN_W-1:0] T_INIT = COIN_W'(START_POT);
  localparam logic [COIN_W-1:0] ANTE_C = COIN_W'(ANTE);
  localparam logic [3:0] C_GIMEL = 4'd3;
  localparam logic [3:0] C_HAY   = 4'd4;
  localparam logic [3:0] C_SHIN  = 4'd5;

  state_e            state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic [COIN_W-1:0] player_q, player_d;
  logic [COIN_W-1:0] pot_q, pot_d;
  logic              updated_q, updated_d;

  logic [COIN_W:0]   req;
  logic [COIN_W-1:0] room;
  logic [COIN_W-1:0] xfer;
  logic              is_gimel, is_hay, is_shin;

  assign is_gimel = (code_q == C_GIMEL);
  assign is_hay   = (code_q == C_HAY);
  assign is_shin  = (code_q == C_SHIN);

  // Coins that would overflow the player stay in the pot.
  always_comb begin
    req  = '0;
    room = MAX - player_q;
    if (is_gimel)
      req = {1'b0, pot_q};
    else if (is_hay)
      req = ({1'b0, pot_q} + 1'b1) >> 1;
    xfer = (req > {1'b0, room}) ? room : req[COIN_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    player_d  = player_q;
    pot_d     = pot_q;
    updated_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (done) begin
          code_d  = gameState;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        unique case (1'b1)
          is_gimel, is_hay: begin
            player_d = player_q + xfer;
            pot_d    = pot_q - xfer;
          end
          is_shin: begin
            if (player_q != '0 && pot_q != MAX) begin
              player_d = player_q - 1'b1;
              pot_d    = pot_q + 1'b1;
            end
          end
          default: ;
        endcase
        state_d = S_ANTE;
      end
      S_ANTE: begin
        if (pot_q == '0 && player_q >= ANTE_C) begin
          player_d = player_q - ANTE_C;
          pot_d    = ANTE_C;
        end
        updated_d = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (!done)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A reload always wins and never lets a stale done be applied.
    if (newGame) begin
      player_d  = P_INIT;
      pot_d     = T_INIT;
      updated_d = 1'b0;
      state_d   = done ? S_WAIT : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      player_q  <= P_INIT;
      pot_q     <= T_INIT;
      updated_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      player_q  <= player_d;
      pot_q     <= pot_d;
      updated_q <= updated_d;
    end
  end

  assign playerCoins = player_q;
  assign potCoins    = pot_q;
  assign updated     = updated_q;
  assign broke       = (player_q == '0);

endmodule

// File: tb/tb_dreidel_pot_ledger.sv
// Scoreboard bench for dreidel_pot_ledger: expected balances queued per spin,
// checked by a monitor on every updated pulse.
module tb_dreidel_pot_ledger;

  logic       clk;
  logic       resetn;
  logic       newGame;
  logic [3:0] gameState;
  logic       done;
  logic [7:0] playerCoins;
  logic [7:0] potCoins;
  logic       updated;
  logic       broke;

  int vectors;
  int miscompares;
  logic [15:0] exp_q[$];
  int pulses;

  dreidel_pot_ledger dut (
    .clk        (clk),
    .resetn     (resetn),
    .newGame    (newGame),
    .gameState  (gameState),
    .done       (done),
    .playerCoins(playerCoins),
    .potCoins   (potCoins),
    .updated    (updated),
    .broke      (broke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every updated pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [15:0] e;
    if (resetn && updated) begin
      pulses++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_update: got player %0d pot %0d, none expected",
                 playerCoins, potCoins);
      end else begin
        e = exp_q.pop_front();
        check("player", int'(playerCoins), int'(e[15:8]));
        check("pot", int'(potCoins), int'(e[7:0]));
        check("broke", int'(broke), int'(e[15:8] == 8'd0));
      end
    end
  end

  task automatic spin(input logic [3:0] c, input int hold,
                      input int ep, input int et);
    exp_q.push_back({8'(ep), 8'(et)});
    @(negedge clk);
    gameState = c;
    done = 1'b1;
    repeat (hold) @(negedge clk);
    done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic new_game();
    @(negedge clk);
    newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    pulses = 0;
    resetn = 1'b0;
    newGame = 1'b0;
    gameState = 4'd0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_player", int'(playerCoins), 10);
    check("reset_pot", int'(potCoins), 4);
    check("reset_updated", int'(updated), 0);
    check("reset_broke", int'(broke), 0);
    resetn = 1'b1;
    @(negedge clk);

    // GIMEL, done held 5 cycles: 14/0 then ante 13/1
    spin(4'd3, 5, 13, 1);
    check("gimel_pulses", pulses, 1);

    // HAY from 10/4: half 2 -> 12/2
    new_game();
    spin(4'd4, 1, 12, 2);
    spin(4'd5, 1, 11, 3);
    spin(4'd5, 1, 10, 4);
    spin(4'd5, 1, 9, 5);
    // HAY with pot 5: half 3 -> 12/2
    spin(4'd4, 1, 12, 2);

    // SHIN down to zero, then SHIN on broke player does nothing
    new_game();
    for (int i = 9; i >= 0; i--)
      spin(4'd5, 1, i, 14 - i);
    spin(4'd5, 1, 0, 14);
    check("broke_flag", int'(broke), 1);
    check("total_conserved", int'(playerCoins) + int'(potCoins), 14);

    // GIMEL with player 0: 14/0 then ante 13/1
    spin(4'd3, 1, 13, 1);

    // NUN held 20 cycles: one pulse; second done gives another
    pulses = 0;
    spin(4'd2, 20, 13, 1);
    check("nun_hold_pulses", pulses, 1);
    spin(4'd2, 1, 13, 1);
    check("nun_second_pulse", pulses, 2);

    // Unknown code treated as NUN
    spin(4'd9, 1, 13, 1);

    // newGame during APPLY aborts a GIMEL
    new_game();
    pulses = 0;
    @(negedge clk);
    gameState = 4'd3;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_player", int'(playerCoins), 10);
    check("abort_pot", int'(potCoins), 4);
    check("abort_pulses", pulses, 0);

    // Async reset while in ANTE
    @(negedge clk);
    gameState = 4'd5;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(posedge clk);
    #2;
    check("ante_pre_player", int'(playerCoins), 9);
    check("ante_pre_pot", int'(potCoins), 5);
    resetn = 1'b0;
    #1;
    check("async_player", int'(playerCoins), 10);
    check("async_pot", int'(potCoins), 4);
    check("async_updated", int'(updated), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("async_no_pulse", pulses, 0);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
